// File: rtl/test_monitor_if.sv
// Snooped write bus, expected-result inputs and status outputs of the test monitor.
interface test_monitor_if #(
   parameter int NUM_RESULTS = 1,
   parameter int CNT_W       = 32
);
   localparam int SEL_W = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;

   logic                      clear;
   logic                      wr_en;
   logic [31:0]               wr_addr;
   logic [31:0]               wr_data;
   logic [3:0]                wr_strb;
   logic [32*NUM_RESULTS-1:0] exp_vals;
   logic [NUM_RESULTS-1:0]    exp_mask;
   logic [SEL_W-1:0]          rd_sel;
   logic [31:0]               rd_data;
   logic                      done;
   logic                      pass;
   logic                      fail;
   logic                      timeout;
   logic [CNT_W-1:0]          cycle_count;

   modport master (
      output clear, wr_en, wr_addr, wr_data, wr_strb, exp_vals, exp_mask, rd_sel,
      input  rd_data, done, pass, fail, timeout, cycle_count
   );

   modport slave (
      input  clear, wr_en, wr_addr, wr_data, wr_strb, exp_vals, exp_mask, rd_sel,
      output rd_data, done, pass, fail, timeout, cycle_count
   );
endinterface

// File: rtl/test_monitor.sv
// Snoops bus writes into result registers and grades the program on a magic done-register write.
// Timeout detection is compiled in only when TEST_MONITOR_TIMEOUT_EN is defined.
module test_monitor #(
   parameter logic [31:0] BASE_ADDR      = 32'h80001000,
   parameter int          NUM_RESULTS    = 1,
   parameter logic [31:0] DONE_MAGIC     = 32'hDEADBEEF,
   parameter int          TIMEOUT_CYCLES = 30000,
   parameter int          CNT_W          = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   test_monitor_if.slave mon
);
   localparam int SEL_W = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;

   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_PASS    = 2'd1;
   localparam logic [1:0] S_FAIL    = 2'd2;
   localparam logic [1:0] S_TIMEOUT = 2'd3;

   logic [1:0]       r_state;
   logic [31:0]      r_res [NUM_RESULTS];
   logic [CNT_W-1:0] r_cnt;

   logic [29:0] w_off;
   logic        w_run;
   logic        w_complete;
   logic        w_match;
   logic        w_timeout_hit;
   logic [1:0]  w_next_state;
   logic        w_unused_addr;

   // Sub-word address bits never select anything in the window.
   assign w_unused_addr = ^mon.wr_addr[1:0];

   assign w_off      = mon.wr_addr[31:2] - BASE_ADDR[31:2];
   assign w_run      = (r_state == S_RUN);
   assign w_complete = w_run && mon.wr_en && (w_off == 30'(NUM_RESULTS))
                       && (mon.wr_strb == 4'hF) && (mon.wr_data == DONE_MAGIC);

`ifdef TEST_MONITOR_TIMEOUT_EN
   assign w_timeout_hit = w_run && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_tmo;
   assign w_unused_tmo  = (TIMEOUT_CYCLES > 0);
   assign w_timeout_hit = 1'b0;
`endif

   always_comb begin
      w_match = 1'b1;
      for (int k = 0; k < NUM_RESULTS; k++) begin
         if (mon.exp_mask[k] && (r_res[k] != mon.exp_vals[32*k +: 32])) begin
            w_match = 1'b0;
         end
      end
   end

   // Completion outranks a timeout landing in the same cycle.
   always_comb begin
      w_next_state = r_state;
      if (w_complete) begin
         w_next_state = w_match ? S_PASS : S_FAIL;
      end else if (w_timeout_hit) begin
         w_next_state = S_TIMEOUT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
         for (int k = 0; k < NUM_RESULTS; k++) r_res[k] <= '0;
      end else if (mon.clear) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
         for (int k = 0; k < NUM_RESULTS; k++) r_res[k] <= '0;
      end else begin
         r_state <= w_next_state;
         // Count only cycles that remain in RUN, so a timeout freezes at TIMEOUT_CYCLES-1.
         if (w_run && (w_next_state == S_RUN) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
         for (int k = 0; k < NUM_RESULTS; k++) begin
            for (int b = 0; b < 4; b++) begin
               if (w_run && mon.wr_en && (w_off == 30'(k)) && mon.wr_strb[b]) begin
                  r_res[k][8*b +: 8] <= mon.wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      mon.rd_data = '0;
      for (int k = 0; k < NUM_RESULTS; k++) begin
         if (mon.rd_sel == SEL_W'(k)) mon.rd_data = r_res[k];
      end
   end

   assign mon.done        = (r_state != S_RUN);
   assign mon.pass        = (r_state == S_PASS);
   assign mon.fail        = (r_state == S_FAIL);
   assign mon.timeout     = (r_state == S_TIMEOUT);
   assign mon.cycle_count = r_cnt;
endmodule

// File: tb/tb_test_monitor.sv
// Randomized and directed bench for test_monitor with a queue-free array reference model.
module tb_test_monitor;
   localparam int          NR    = 4;
   localparam logic [31:0] BASE  = 32'h80001000;
   localparam logic [31:0] MAGIC = 32'hDEADBEEF;
   localparam logic [31:0] DONEA = BASE + 32'(4 * NR);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   logic [31:0] model_res [NR];
   bit          model_run;
   logic        model_pass;

   test_monitor_if #(.NUM_RESULTS(NR), .CNT_W(32)) mon ();

   test_monitor #(
      .BASE_ADDR(BASE), .NUM_RESULTS(NR), .DONE_MAGIC(MAGIC),
      .TIMEOUT_CYCLES(100), .CNT_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mon(mon)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NR; k++) model_res[k] = '0;
      model_run  = 1'b1;
      model_pass = 1'b0;
   endfunction

   // Word offset from the window base; only in-window result writes while running land.
   function automatic void model_wr(input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] s, input logic en);
      logic [31:0] base_v = BASE;
      logic [29:0] off = a[31:2] - base_v[31:2];
      if (en && model_run && off < 30'(NR)) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) model_res[off][8*b +: 8] = d[8*b +: 8];
         end
      end
      if (en && model_run && off == 30'(NR) && s == 4'hF && d == MAGIC) begin
         model_run  = 1'b0;
         model_pass = 1'b1;
         for (int k = 0; k < NR; k++) begin
            if (mon.exp_mask[k] && model_res[k] != mon.exp_vals[32*k +: 32]) model_pass = 1'b0;
         end
      end
   endfunction

   // Caller is at a negedge; returns at the next negedge with the write committed.
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic en);
      model_wr(a, d, s, en);
      mon.wr_en = en; mon.wr_addr = a; mon.wr_data = d; mon.wr_strb = s;
      @(negedge clk);
      mon.wr_en = 1'b0;
   endtask

   task automatic do_clear();
      mon.clear = 1'b1;
      @(negedge clk);
      mon.clear = 1'b0;
      model_reset();
   endtask

   task automatic check_res(input string tag);
      for (int k = 0; k < NR; k++) begin
         mon.rd_sel = 2'(k);
         #1;
         check($sformatf("%s_res%0d", tag, k), 64'(mon.rd_data), 64'(model_res[k]));
      end
   endtask

   task automatic check_flags(input string tag, input logic d, input logic p,
                              input logic f, input logic t);
      check({tag, "_done"}, 64'(mon.done), 64'(d));
      check({tag, "_pass"}, 64'(mon.pass), 64'(p));
      check({tag, "_fail"}, 64'(mon.fail), 64'(f));
      check({tag, "_tmo"},  64'(mon.timeout), 64'(t));
   endtask

   initial begin
      logic [31:0] a, d;
      logic [3:0]  s;
      logic        en;
      int          n, pick, k;

      mon.clear = 1'b0; mon.wr_en = 1'b0; mon.wr_addr = '0; mon.wr_data = '0;
      mon.wr_strb = '0; mon.exp_vals = '0; mon.exp_mask = '0; mon.rd_sel = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_flags("reset", 0, 0, 0, 0);
      check("reset_cnt", 64'(mon.cycle_count), 64'd0);
      check_res("reset");
      @(negedge clk);
      rst_n = 1'b1;

      n = $urandom_range(5, 20);
      repeat (n) @(negedge clk);
      check("count_run", 64'(mon.cycle_count), 64'(n));

      for (int i = 0; i < 14; i++) begin
         pick = $urandom_range(0, 6);
         k    = $urandom_range(0, NR - 1);
         d    = $urandom;
         s    = 4'($urandom_range(0, 15));
         en   = 1'b1;
         if (pick == 4)      a = BASE + 32'(4 * (NR + 1 + $urandom_range(0, 8)));
         else if (pick == 5) a = BASE - 32'd4;
         else if (pick == 6) begin a = BASE + 32'(4 * k); en = 1'b0; end
         else                a = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
         bus_wr(a, d, s, en);
      end
      check_res("randwr");
      check_flags("randwr", 0, 0, 0, 0);

      do_clear();
      bus_wr(BASE + 32'd8, 32'h11223344, 4'hF, 1'b1);
      bus_wr(BASE + 32'd8, 32'h000000AA, 4'b0001, 1'b1);
      mon.rd_sel = 2'd2;
      #1;
      check("strb_byte", 64'(mon.rd_data), 64'h112233AA);

      bus_wr(DONEA, MAGIC, 4'b0111, 1'b1);
      check("bad_strb_done", 64'(mon.done), 64'd0);
      bus_wr(DONEA, 32'hDEADBEE0, 4'hF, 1'b1);
      check("bad_magic_done", 64'(mon.done), 64'd0);

      do_clear();
      mon.exp_vals = '0; mon.exp_vals[31:0] = 32'd2; mon.exp_mask = 4'b0001;
      bus_wr(BASE, 32'd2, 4'hF, 1'b1);
      bus_wr(DONEA, MAGIC, 4'hF, 1'b1);
      check_flags("dir_pass", 1, 1, 0, 0);
      mon.rd_sel = 2'd0;
      #1;
      check("dir_pass_rd", 64'(mon.rd_data), 64'd2);

      do_clear();
      bus_wr(BASE, 32'd3, 4'hF, 1'b1);
      bus_wr(DONEA, MAGIC, 4'hF, 1'b1);
      check_flags("dir_fail", 1, 0, 1, 0);

      for (int r = 0; r < 6; r++) begin
         do_clear();
         for (int j = 0; j < NR; j++) bus_wr(BASE + 32'(4 * j), $urandom, 4'hF, 1'b1);
         for (int j = 0; j < NR; j++) begin
            mon.exp_vals[32*j +: 32] = ($urandom_range(0, 2) == 0)
               ? (model_res[j] ^ (32'd1 << $urandom_range(0, 31))) : model_res[j];
         end
         mon.exp_mask = (r == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         bus_wr(DONEA, MAGIC, 4'hF, 1'b1);
         check_flags($sformatf("rnd%0d", r), 1, model_pass, !model_pass, 0);
         bus_wr(BASE, ~model_res[0], 4'hF, 1'b1);
         bus_wr(DONEA, MAGIC, 4'hF, 1'b1);
         repeat (3) @(negedge clk);
         check_flags($sformatf("rnd%0d_hold", r), 1, model_pass, !model_pass, 0);
         check_res($sformatf("rnd%0d_term", r));
      end

      do_clear();
      mon.exp_mask = '0;
      bus_wr(DONEA, MAGIC, 4'hF, 1'b1);
      mon.clear = 1'b1;
      bus_wr(BASE, 32'h55, 4'hF, 1'b1);
      mon.clear = 1'b0;
      model_reset();
      check_flags("clr_wr", 0, 0, 0, 0);
      check("clr_wr_cnt", 64'(mon.cycle_count), 64'd0);
      check_res("clr_wr");

      bus_wr(DONEA, MAGIC, 4'hF, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_flags("async_rst", 0, 0, 0, 0);
      check("async_rst_cnt", 64'(mon.cycle_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (7) @(negedge clk);
      check("rst_resume_cnt", 64'(mon.cycle_count), 64'd7);

      do_clear();
      repeat (99) @(negedge clk);
      check("pre_tmo_cnt", 64'(mon.cycle_count), 64'd99);
      bus_wr(DONEA, MAGIC, 4'hF, 1'b1);
      check_flags("cmpl_vs_tmo", 1, 1, 0, 0);

      do_clear();
      repeat (99) @(negedge clk);
      check("tmo_edge_done", 64'(mon.done), 64'd0);
`ifdef TEST_MONITOR_TIMEOUT_EN
      @(negedge clk);
      check_flags("tmo", 1, 0, 0, 1);
      check("tmo_cnt", 64'(mon.cycle_count), 64'd99);
      repeat (5) @(negedge clk);
      check("tmo_cnt_frozen", 64'(mon.cycle_count), 64'd99);
`else
      repeat (21) @(negedge clk);
      check_flags("no_tmo", 0, 0, 0, 0);
      check("no_tmo_cnt", 64'(mon.cycle_count), 64'd120);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h80001000, word-aligned byte address of the monitor window.
REQ-002 SHALL have parameter NUM_RESULTS, default 1, range 1..8, number of 32-bit result registers.
REQ-003 SHALL have parameter DONE_MAGIC, default 32'hDEADBEEF, value that signals program completion.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 30000, RUN cycles before timeout.
REQ-005 SHALL have parameter CNT_W, default 32, cycle counter width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 clear  input  1  synchronous re-arm: results, counter and state return to reset values.
REQ-009 wr_en  input  1  snooped bus write strobe.
REQ-010 wr_addr  input  32  snooped byte address.
REQ-011 wr_data  input  32  snooped write data.
REQ-012 wr_strb  input  4  byte enables, bit i covers wr_data[8i+7:8i].
REQ-013 exp_vals  input  32*NUM_RESULTS  expected results, channel k at [32k+31:32k].
REQ-014 exp_mask  input  NUM_RESULTS  1 = channel k is checked.
REQ-015 rd_sel  input  $clog2(NUM_RESULTS) (min 1)  result register read select.
REQ-016 rd_data  output  32  combinational read of result[rd_sel]; 0 if rd_sel out of range.
REQ-017 done / pass / fail / timeout  output  1 each  terminal status flags.
REQ-018 cycle_count  output  CNT_W  RUN cycles elapsed.

Function
REQ-019 SHALL implement states RUN, PASS, FAIL, TIMEOUT; RUN is the only non-terminal state.
REQ-020 Window: word offset k = (wr_addr[31:2] - BASE_ADDR[31:2]); offsets 0..NUM_RESULTS-1 are results, offset NUM_RESULTS is the done register; wr_addr[1:0] SHALL be ignored.
REQ-021 Writes outside the window, or with wr_en=0, SHALL have no effect.
REQ-022 Result writes in RUN SHALL update only bytes whose wr_strb bit is set, visible on rd_data the next cycle.
REQ-023 A done-register write in RUN with wr_strb=4'hF and wr_data==DONE_MAGIC SHALL trigger completion; any other done-register write SHALL be ignored.
REQ-024 On completion: every channel with exp_mask[k]=1 compared to exp_vals[k]; all equal -> PASS, else FAIL; exp_mask all zero -> PASS.
REQ-025 done SHALL assert in the cycle after the triggering write, together with exactly one of pass/fail/timeout.
REQ-026 cycle_count SHALL increment each RUN cycle, saturate at all-ones, and freeze in terminal states.
REQ-027 When cycle_count reaches TIMEOUT_CYCLES-1 in RUN with no completion that cycle, next state SHALL be TIMEOUT; a completion in that same cycle SHALL take priority.
REQ-028 Writes in terminal states SHALL be ignored; flags SHALL hold until clear or reset.
REQ-029 clear SHALL take priority over a same-cycle write and over completion/timeout.

Reset
REQ-030 rst_n low SHALL asynchronously force state RUN, all results 0, cycle_count 0, done/pass/fail/timeout 0.
REQ-031 Reset deassertion mid-program SHALL resume counting from 0 on the next rising edge.

Configuration
REQ-032 With macro TEST_MONITOR_TIMEOUT_EN defined, REQ-027 timeout logic SHALL be compiled in.
REQ-033 Without TEST_MONITOR_TIMEOUT_EN, timeout SHALL be tied 0, TIMEOUT state unreachable, and cycle_count SHALL still count and saturate.

Verification
REQ-034 Defaults; write 0x2 to 0x80001000, then 0xDEADBEEF to 0x80001004, exp_vals=2, exp_mask=1 -> next cycle done=1, pass=1, rd_data=2.
REQ-035 Same, result written 0x3 -> done=1, fail=1, pass=0.
REQ-036 NUM_RESULTS=4; write 0x000000AA with wr_strb=4'b0001 over 0x11223344 at offset 2 -> rd_data(rd_sel=2)=0x112233AA.
REQ-037 Done-register write of 0xDEADBEEF with wr_strb=4'b0111, or of 0xDEADBEE0 -> done stays 0.
REQ-038 TIMEOUT_CYCLES=100, TEST_MONITOR_TIMEOUT_EN defined, no writes -> timeout=1, done=1 after 100 RUN cycles, cycle_count=99 frozen; without macro -> timeout=0, count continues.
REQ-039 In PASS, assert clear together with a result write -> all flags 0, results 0, cycle_count 0 next cycle.
